// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Pipeline hazard unit for an in-order 5-stage core with a multi-cycle
//   mul/div unit (MDU). It selects operand forwarding sources for the ID
//   stage. It detects load-use hazards and MDU RAW, WAW and structural
//   hazards. It tracks the single in-flight MDU op and signals its completion.
//   It also counts stalled cycles for performance monitoring.
//
// Parameters:
//   REG_ADDR_W   register address width
//   MDU_LATENCY  mul/div latency in cycles (legal range 2..15)
//   STALL_CNT_W  width of the saturating stall counter
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   id_valid                       ID stage holds a real instruction
//   rs_id, rt_id, rs_used, rt_used ID source registers and their read flags
//   id_rd, id_we                   ID destination and write enable
//   mdu_start                      ID instruction is a mul/div request
//   ex_rd, ex_we, ex_is_load       EX stage destination info
//   mem_rd, mem_we, mem_is_load    MEM stage destination info
//   wb_rd, wb_we                   WB stage destination info
//   forward_a, forward_b           operand source (00 RF, 10 MEM, 01 WB)
//   stall                          hold PC/IF/ID and bubble EX
//   mdu_busy                       a mul/div op is in flight
//   mdu_wb_valid, mdu_wb_rd        one-cycle MDU completion pulse and dest
//   stall_count                    number of stalled cycles (saturating)
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  rs_id,
    input  logic [REG_ADDR_W-1:0]  rt_id,
    input  logic                   rs_used,
    input  logic                   rt_used,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_we,
    input  logic                   mdu_start,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_we,
    input  logic                   ex_is_load,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   mem_we,
    input  logic                   mem_is_load,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   wb_we,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   stall,
    output logic                   mdu_busy,
    output logic                   mdu_wb_valid,
    output logic [REG_ADDR_W-1:0]  mdu_wb_rd,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Four bits cover the whole legal latency range of 2..15.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LATENCY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [CNT_W-1:0]      cnt;
    logic [REG_ADDR_W-1:0] pend_rd;

    logic rs_nz, rt_nz, rd_nz;
    logic cnt_gt1;
    logic stall_lu, stall_raw, stall_waw, stall_st;
    logic accept;

    // Register 0 is hardwired to zero, so it never takes part in a hazard.
    assign rs_nz   = (rs_id != '0);
    assign rt_nz   = (rt_id != '0);
    assign rd_nz   = (id_rd != '0);
    assign cnt_gt1 = (cnt > ONE);

    // Operand forwarding. MEM wins over WB because it holds the younger
    // value. A load in MEM has no data yet. Its result is picked up from WB
    // on the next cycle, so a load in MEM is not a forwarding source here.
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (rs_nz && mem_we && !mem_is_load && (rs_id == mem_rd))
            forward_a = FWD_MEM;
        else if (rs_nz && wb_we && (rs_id == wb_rd))
            forward_a = FWD_WB;
        if (rt_nz && mem_we && !mem_is_load && (rt_id == mem_rd))
            forward_b = FWD_MEM;
        else if (rt_nz && wb_we && (rt_id == wb_rd))
            forward_b = FWD_WB;
    end

    // Hazard detection. When cnt==1 the MDU result is being written back
    // this cycle. The datapath bypasses it, so RAW and WAW only stall
    // while cnt>1.
    assign stall_lu  = id_valid && ex_we && ex_is_load &&
                       ((rs_used && rs_nz && (rs_id == ex_rd)) ||
                        (rt_used && rt_nz && (rt_id == ex_rd)));
    assign stall_raw = id_valid && cnt_gt1 &&
                       ((rs_used && rs_nz && (rs_id == pend_rd)) ||
                        (rt_used && rt_nz && (rt_id == pend_rd)));
    assign stall_waw = id_valid && id_we && cnt_gt1 && rd_nz &&
                       (id_rd == pend_rd);
    assign stall_st  = id_valid && mdu_start && cnt_gt1;

    assign stall  = stall_lu || stall_raw || stall_waw || stall_st;
    assign accept = id_valid && mdu_start && !stall;

    assign mdu_busy     = (cnt != '0);
    assign mdu_wb_valid = (cnt == ONE);
    assign mdu_wb_rd    = pend_rd;

    // MDU tracker. Acceptance reloads the countdown. Acceptance is allowed
    // on the cnt==1 cycle, so the old op still pulses while the new one
    // starts, giving back-to-back issue. Reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pend_rd <= '0;
        end else if (accept) begin
            cnt     <= LAT;
            pend_rd <= id_rd;
        end else if (cnt != '0) begin
            cnt     <= cnt - ONE;
        end
    end

    // Stall performance counter. It saturates at all-ones rather than
    // wrapping, so a long run never reports a misleadingly small number.
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Purpose:
//   Directed self-checking bench for hazard_scoreboard. A second instance
//   with a 4-bit stall counter shares every input and is used to observe
//   counter saturation.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] rs_id, rt_id;
    logic          rs_used, rt_used;
    logic [AW-1:0] id_rd;
    logic          id_we;
    logic          mdu_start;
    logic [AW-1:0] ex_rd;
    logic          ex_we, ex_is_load;
    logic [AW-1:0] mem_rd;
    logic          mem_we, mem_is_load;
    logic [AW-1:0] wb_rd;
    logic          wb_we;

    logic [1:0]    forward_a, forward_b;
    logic          stall, mdu_busy, mdu_wb_valid;
    logic [AW-1:0] mdu_wb_rd;
    logic [31:0]   stall_count;

    logic [1:0]    s_forward_a, s_forward_b;
    logic          s_stall, s_mdu_busy, s_mdu_wb_valid;
    logic [AW-1:0] s_mdu_wb_rd;
    logic [3:0]    s_stall_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_sc       = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(AW), .MDU_LATENCY(4), .STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .id_rd(id_rd), .id_we(id_we), .mdu_start(mdu_start),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
        .mdu_busy(mdu_busy), .mdu_wb_valid(mdu_wb_valid),
        .mdu_wb_rd(mdu_wb_rd), .stall_count(stall_count)
    );

    hazard_scoreboard #(.REG_ADDR_W(AW), .MDU_LATENCY(4), .STALL_CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .id_rd(id_rd), .id_we(id_we), .mdu_start(mdu_start),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .forward_a(s_forward_a), .forward_b(s_forward_b), .stall(s_stall),
        .mdu_busy(s_mdu_busy), .mdu_wb_valid(s_mdu_wb_valid),
        .mdu_wb_rd(s_mdu_wb_rd), .stall_count(s_stall_count)
    );

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return every pipeline input to an idle, non-matching value.
    task automatic clearInputs();
        id_valid = 0; rs_id = '0; rt_id = '0; rs_used = 0; rt_used = 0;
        id_rd = '0; id_we = 0; mdu_start = 0;
        ex_rd = '0; ex_we = 0; ex_is_load = 0;
        mem_rd = '0; mem_we = 0; mem_is_load = 0;
        wb_rd = '0; wb_we = 0;
    endtask

    // Drive the ID-stage instruction fields.
    task automatic applyStimulus(input logic v, input logic [AW-1:0] rs,
                                 input logic rsu, input logic [AW-1:0] rt,
                                 input logic rtu, input logic [AW-1:0] rd,
                                 input logic we, input logic start);
        id_valid = v; rs_id = rs; rs_used = rsu; rt_id = rt; rt_used = rtu;
        id_rd = rd; id_we = we; mdu_start = start;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        checkOutput("reset_busy", 32'(mdu_busy), 32'd0);
        checkOutput("reset_wbv", 32'(mdu_wb_valid), 32'd0);
        checkOutput("reset_count", stall_count, 32'd0);
        checkOutput("reset_fwd_a", 32'(forward_a), 32'd0);

        // Forwarding: MEM priority, load in MEM defers to WB, r0 never forwards.
        mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1; rs_id = 5; rt_id = 5;
        #1;
        checkOutput("fwd_a_mem", 32'(forward_a), 32'd2);
        checkOutput("fwd_b_mem", 32'(forward_b), 32'd2);
        mem_is_load = 1;
        #1;
        checkOutput("fwd_a_load_wb", 32'(forward_a), 32'd1);
        mem_is_load = 0; mem_we = 0; rt_id = 6;
        #1;
        checkOutput("fwd_a_wb_only", 32'(forward_a), 32'd1);
        checkOutput("fwd_b_nomatch", 32'(forward_b), 32'd0);
        rs_id = 0; rt_id = 0; mem_rd = 0; mem_we = 1; wb_rd = 0; wb_we = 1;
        #1;
        checkOutput("fwd_a_r0", 32'(forward_a), 32'd0);
        checkOutput("fwd_b_r0", 32'(forward_b), 32'd0);

        // Load-use hazards.
        clearInputs();
        ex_we = 1; ex_is_load = 1; ex_rd = 7;
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 0);
        #1;
        checkOutput("lu_rt_stall", 32'(stall), 32'd1);
        tick();
        exp_sc = 1;
        checkOutput("lu_count1", stall_count, 32'(exp_sc));
        applyStimulus(1, 0, 0, 7, 0, 0, 0, 0);
        #1;
        checkOutput("lu_rt_unused", 32'(stall), 32'd0);
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("lu_rs_stall", 32'(stall), 32'd1);
        tick();
        exp_sc = 2;
        id_valid = 0;
        #1;
        checkOutput("lu_invalid", 32'(stall), 32'd0);
        tick();
        checkOutput("lu_count2", stall_count, 32'(exp_sc));
        ex_is_load = 0;
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("ex_alu_nostall", 32'(stall), 32'd0);
        ex_is_load = 1; ex_rd = 0;
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
        #1;
        checkOutput("lu_r0", 32'(stall), 32'd0);

        // MDU op to r9 with a dependent consumer waiting behind it.
        clearInputs();
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1);
        #1;
        checkOutput("mdu_accept_nostall", 32'(stall), 32'd0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1, 9, 1, 0, 0, 3, 1, 0);
            #1;
            checkOutput($sformatf("raw_busy_c%0d", c), 32'(mdu_busy), 32'd1);
            checkOutput($sformatf("raw_wbv_c%0d", c), 32'(mdu_wb_valid), 32'(c == 4));
            checkOutput($sformatf("raw_stall_c%0d", c), 32'(stall), 32'(c < 4));
            if (c == 4) checkOutput("raw_wb_rd", 32'(mdu_wb_rd), 32'd9);
            if (c < 4) exp_sc++;
            tick();
        end
        clearInputs();
        #1;
        checkOutput("raw_idle_busy", 32'(mdu_busy), 32'd0);
        checkOutput("raw_idle_wbv", 32'(mdu_wb_valid), 32'd0);
        checkOutput("raw_count", stall_count, 32'(exp_sc));

        // Back-to-back MDU ops: structural stall, then overlap on cnt==1.
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1);
        tick();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1, 0, 0, 0, 0, 10, 1, 1);
            #1;
            checkOutput($sformatf("st_stall_c%0d", c), 32'(stall), 32'(c < 4));
            checkOutput($sformatf("st_wbv_c%0d", c), 32'(mdu_wb_valid), 32'(c == 4));
            if (c == 4) checkOutput("st_wb_rd_first", 32'(mdu_wb_rd), 32'd9);
            if (c < 4) exp_sc++;
            tick();
        end
        for (int c = 5; c <= 8; c++) begin
            if (c == 6 || c == 8) applyStimulus(1, 0, 0, 0, 0, 10, 1, 0);
            else clearInputs();
            #1;
            checkOutput($sformatf("st_busy_c%0d", c), 32'(mdu_busy), 32'd1);
            checkOutput($sformatf("st_wbv_c%0d", c), 32'(mdu_wb_valid), 32'(c == 8));
            checkOutput($sformatf("waw_stall_c%0d", c), 32'(stall), 32'(c == 6));
            if (c == 8) checkOutput("st_wb_rd_second", 32'(mdu_wb_rd), 32'd10);
            if (c == 6) exp_sc++;
            tick();
        end
        clearInputs();
        #1;
        checkOutput("st_idle_busy", 32'(mdu_busy), 32'd0);
        checkOutput("st_count", stall_count, 32'(exp_sc));

        // Reset in the middle of an MDU op discards it and wins over acceptance.
        applyStimulus(1, 0, 0, 0, 0, 12, 1, 1);
        tick();
        clearInputs();
        tick();
        rst = 1;
        applyStimulus(1, 0, 0, 0, 0, 13, 1, 1);
        #1;
        checkOutput("rst_mid_stall", 32'(stall), 32'd1);
        tick();
        rst = 0;
        clearInputs();
        exp_sc = 0;
        #1;
        checkOutput("rst_mid_busy", 32'(mdu_busy), 32'd0);
        checkOutput("rst_mid_count", stall_count, 32'(exp_sc));
        checkOutput("rst_mid_small_count", 32'(s_stall_count), 32'd0);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("rst_no_pulse_%0d", c), 32'(mdu_wb_valid), 32'd0);
            tick();
        end

        // Hold a load-use stall long enough to saturate the 4-bit counter.
        ex_we = 1; ex_is_load = 1; ex_rd = 7;
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_sc++;
            if (i == 15) checkOutput("sat_reach15", 32'(s_stall_count), 32'd15);
            if (i == 20) checkOutput("sat_hold15", 32'(s_stall_count), 32'd15);
        end
        checkOutput("sat_wide_count", stall_count, 32'(exp_sc));

        clearInputs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
